ca_code_gen: RTL and testbench
==============================

# ca_code_gen

GPS L1 C/A Gold-code generator that consumes the `clk_out` square wave of the Doppler-compensated DDS. Each rising edge of that wave advances the code by one chip. The block produces the 1023-chip PRN sequence for a selected satellite (PRN 1..32), plus the chip index, a 1 ms code-epoch strobe and a 20 ms navigation-bit boundary strobe. It sits directly downstream of the DDS and feeds the correlator/despreader.

## Interface
- `MS_PER_BIT`, default 20: code epochs per navigation bit; `ms_cnt` wraps at `MS_PER_BIT-1`.

- `clk` in 1: system clock, same clock as the DDS.
- `rst_n` in 1: asynchronous, active-low reset.
- `chip_clk` in 1: DDS square-wave output, synchronous to `clk`. Each rising edge is one chip strobe.
- `enable` in 1: when low, strobes are ignored and the state is frozen.
- `load` in 1: single-cycle restart pulse.
  - Latches `prn`.
  - Sets G1 and G2 to all ones.
  - Clears `chip_idx` and `ms_cnt`.
- `prn` in 6: satellite number, sampled only on `load`.
- `chip` out 1: current code chip, 1 = logic one. Forced to 0 when `valid`=0.
- `chip_idx` out 10: index of the current chip, 0..1022.
- `epoch` out 1: one-cycle pulse, high in the cycle `chip_idx` wraps 1022→0.
- `ms_cnt` out 5: epoch counter, 0..MS_PER_BIT-1.
- `bit_edge` out 1: one-cycle pulse, coincident with `epoch` when `ms_cnt` wraps to 0.
- `valid` out 1: a legal PRN is loaded.
- `prn_err` out 1: the last `load` carried a PRN of 0 or greater than 32.

## Operation
- **Strobe detection**
  - The register `chip_clk_q` holds `chip_clk` delayed by one cycle.
  - `stb = chip_clk & ~chip_clk_q & enable & valid`.
  - A falling edge does nothing.
- **G1 register** (10 bits, stages 1..10)
  - Feedback = s3 ^ s10 (polynomial 1+x³+x¹⁰).
  - Shift toward s10; the feedback enters s1.
- **G2 register** (10 bits)
  - Feedback = s2^s3^s6^s8^s9^s10 (polynomial 1+x²+x³+x⁶+x⁸+x⁹+x¹⁰).
  - Same shift direction as G1.
- **Chip output:** `chip = G1.s10 ^ G2.sA ^ G2.sB`.
  - (A,B) is the ICD-GPS-200 phase-selector pair for the latched PRN, from a constant 32-entry lookup.
  - Examples: PRN1=(2,6), PRN2=(3,7), PRN3=(4,8), PRN32=(4,9).
  - `chip` is combinational from registered state only.
- **On `stb`**
  - Both LFSRs shift.
  - `chip_idx` increments.
  - At `chip_idx`=1022, the next value is 0 and `epoch` is set for one cycle. The LFSRs return to all ones naturally.
  - On `epoch`, `ms_cnt` increments, wrapping MS_PER_BIT-1→0. That wrap also sets `bit_edge`.
- **On `load`**
  - Stores `prn`.
  - Sets `valid = (1 ≤ prn ≤ 32)` and `prn_err = ~valid`.
  - Initialises G1 and G2 to all ones, and clears `chip_idx`, `ms_cnt`, `epoch` and `bit_edge`.
- **Invalid PRN**
  - The LFSRs are held, `chip`=0 and no strobes are taken.
  - The state persists until a later `load` with a legal PRN.

## Timing
- **Reset values:** `chip`=0, `chip_idx`=0, `epoch`=0, `ms_cnt`=0, `bit_edge`=0, `valid`=0, `prn_err`=0. Internally, G1 and G2 are all ones, `chip_clk_q`=0 and the latched PRN is 0.
- **Reset mid-operation:** all state returns to the reset values immediately, asynchronously. A `load` is required before chips are produced again.
- **Strobe latency**
  - Let cycle n be the first cycle in which `chip_clk`=1 after a 0.
  - The new `chip`, `chip_idx` and pulses are visible in cycle n+1.
- **Load latency**
  - Asserting `load` in cycle n makes chip 0 of the new PRN visible in cycle n+1.
  - `valid` and `prn_err` also update in n+1.
- **Load and strobe in the same cycle:** `load` wins and the strobe is discarded.
- **`enable` low during a rising edge:** that edge is lost; it is not queued.
- **Strobe rate:** at most one strobe per two `clk` cycles, because `chip_clk` must be low for at least one sampled cycle. Back-to-back edges need no extra handling.
- **Pulse alignment:** `epoch` and `bit_edge` are exactly one `clk` cycle wide and aligned with `chip_idx` reading 0.

## Test plan
- **Reset check:** assert `rst_n`=0 mid-sequence → all outputs take their reset values asynchronously, within the same cycle. After release, `valid`=0 and toggling `chip_clk` leaves `chip_idx`=0.
- **PRN1 sequence:** `load` with `prn`=1, then 10 rising edges of `chip_clk` → first 10 chips 1100100000 (octal 1440).
- **PRN2 sequence:** `load` with `prn`=2 → first 10 chips 1110010000 (octal 1620).
- **Period and bit edge (PRN1):** after 1023 strobes, `epoch` pulses once with `chip_idx`=0. The chip sequence repeats from octal 1440. After 20 epochs, `ms_cnt` reads 0 and `bit_edge` is coincident with the 20th `epoch`.
- **Invalid PRN:** `load` with `prn`=0, then `prn`=33 → `valid`=0, `prn_err`=1, `chip`=0. With strobes applied, `chip_idx` stays 0.
- **Priority and enable:** at `chip_idx`=500, assert `load` in the same cycle as a strobe → `chip_idx`=0 in the next cycle. With `enable`=0 over 5 rising edges, `chip_idx` is unchanged.

Source files
------------

// File: rtl/ca_code_if.sv
// ca_code_if: chip-strobe/load controls in, Gold-code chip, index and epoch strobes out.
//   master: drives chip_clk, enable, load, prn; observes chip, chip_idx, epoch, ms_cnt, bit_edge, valid, prn_err
//   slave : the code generator side of the same signals
interface ca_code_if;
    logic       chip_clk;
    logic       enable;
    logic       load;
    logic [5:0] prn;
    logic       chip;
    logic [9:0] chip_idx;
    logic       epoch;
    logic [4:0] ms_cnt;
    logic       bit_edge;
    logic       valid;
    logic       prn_err;
    modport master (
        output chip_clk, enable, load, prn,
        input  chip, chip_idx, epoch, ms_cnt, bit_edge, valid, prn_err
    );
    modport slave (
        input  chip_clk, enable, load, prn,
        output chip, chip_idx, epoch, ms_cnt, bit_edge, valid, prn_err
    );
endinterface

// File: rtl/ca_code_gen.sv
// ca_code_gen: GPS L1 C/A Gold-code generator advanced by rising edges of the DDS chip clock.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : ca_code_if slave (chip_clk/enable/load/prn in; chip, chip_idx, epoch,
//                ms_cnt, bit_edge, valid, prn_err out)
module ca_code_gen #(
    parameter int MS_PER_BIT = 20
) (
    input logic      clk,
    input logic      rst_n,
    ca_code_if.slave bus
);
    // G2 phase-selector stage pairs {A,B} (1-based, hex nibbles) for PRN 1..32
    localparam logic [7:0] TAPS [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2a, 8'h18, 8'h29,
        8'h3a, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9a,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8a, 8'h16, 8'h27, 8'h38, 8'h49
    };
    logic       chip_clk_q;
    logic [5:0] prn_q;
    logic [9:0] g1, g2, idx, sel;
    logic [4:0] ms;
    logic [7:0] tap;
    logic       epoch, bit_edge, valid, prn_err;
    logic       stb, wrap, last, legal;
    assign stb   = bus.chip_clk & ~chip_clk_q & bus.enable & valid;
    assign wrap  = idx == 10'd1022;
    assign last  = ms == 5'(MS_PER_BIT - 1);
    assign legal = bus.prn != 6'd0 && bus.prn <= 6'd32;
    // PRN 32 maps to index 31 through the 5-bit wrap; illegal PRNs are masked by valid
    assign tap   = TAPS[prn_q[4:0] - 5'd1];
    assign sel   = (10'd1 << (tap[7:4] - 4'd1)) | (10'd1 << (tap[3:0] - 4'd1));
    // g1[k-1] is stage k, so bit 9 is s10
    assign bus.chip     = valid & (g1[9] ^ (^(g2 & sel)));
    assign bus.chip_idx = idx;
    assign bus.epoch    = epoch;
    assign bus.ms_cnt   = ms;
    assign bus.bit_edge = bit_edge;
    assign bus.valid    = valid;
    assign bus.prn_err  = prn_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chip_clk_q <= 1'b0;
            prn_q      <= '0;
            g1         <= '1;
            g2         <= '1;
            idx        <= '0;
            ms         <= '0;
            epoch      <= 1'b0;
            bit_edge   <= 1'b0;
            valid      <= 1'b0;
            prn_err    <= 1'b0;
        end else begin
            chip_clk_q <= bus.chip_clk;
            epoch      <= 1'b0;
            bit_edge   <= 1'b0;
            if (bus.load) begin
                prn_q   <= bus.prn;
                valid   <= legal;
                prn_err <= ~legal;
                g1      <= '1;
                g2      <= '1;
                idx     <= '0;
                ms      <= '0;
            end else if (stb) begin
                g1  <= {g1[8:0], g1[2] ^ g1[9]};
                g2  <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
                idx <= wrap ? 10'd0 : idx + 10'd1;
                if (wrap) begin
                    epoch    <= 1'b1;
                    bit_edge <= last;
                    ms       <= last ? 5'd0 : ms + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ca_code_gen.sv
// tb_ca_code_gen: randomized and directed checks of ca_code_gen against a delay-table Gold-code model.
module tb_ca_code_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ca_code_if bus ();
    ca_code_gen #(.MS_PER_BIT(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    // G2 delays in chips for PRN 1..32 (ICD-GPS-200 table)
    int dly [1:32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                       469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};
    bit g1s [1033];
    bit g2s [1033];
    int tests = 0;
    int fails = 0;
    int m_prn, m_idx, m_ms, n_ep, n_be;
    bit m_valid, m_err, m_ep, m_be;

    function automatic bit gold(input int p, input int n);
        return g1s[n] ^ g2s[(n + 1023 - dly[p]) % 1023];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".chip"}, 32'(bus.chip), 32'(m_valid ? gold(m_prn, m_idx) : 1'b0));
        chk({tag, ".chip_idx"}, 32'(bus.chip_idx), 32'(m_idx));
        chk({tag, ".epoch"}, 32'(bus.epoch), 32'(m_ep));
        chk({tag, ".ms_cnt"}, 32'(bus.ms_cnt), 32'(m_ms));
        chk({tag, ".bit_edge"}, 32'(bus.bit_edge), 32'(m_be));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(m_valid));
        chk({tag, ".prn_err"}, 32'(bus.prn_err), 32'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_prn = 1; m_idx = 0; m_ms = 0; m_valid = 0; m_err = 0; m_ep = 0; m_be = 0;
    endtask

    task automatic do_load(input int p, input bit cc);
        bus.prn = 6'(p);
        bus.load = 1'b1;
        bus.chip_clk = cc;
        cyc();
        bus.load = 1'b0;
        m_valid = p >= 1 && p <= 32;
        m_err = !m_valid;
        if (m_valid) m_prn = p;
        m_idx = 0; m_ms = 0; m_ep = 0; m_be = 0;
        check_all("load");
        bus.chip_clk = 1'b0;
        cyc();
        check_all("load_idle");
    endtask

    task automatic do_strobe(input bit en);
        bus.chip_clk = 1'b1;
        bus.enable = en;
        cyc();
        m_ep = 0; m_be = 0;
        if (en && m_valid) begin
            m_idx = (m_idx + 1) % 1023;
            if (m_idx == 0) begin
                m_ep = 1;
                m_ms = (m_ms + 1) % 20;
                m_be = m_ms == 0;
            end
        end
        if (bus.epoch) n_ep++;
        if (bus.bit_edge) n_be++;
        check_all("rise");
        bus.chip_clk = 1'b0;
        cyc();
        m_ep = 0; m_be = 0;
        check_all("fall");
        bus.enable = 1'b1;
    endtask

    task automatic first10(input string tag, input logic [9:0] exp);
        logic [9:0] code = '0;
        for (int i = 0; i < 10; i++) begin
            code = {code[8:0], bus.chip};
            do_strobe(1'b1);
        end
        chk(tag, 32'(code), 32'(exp));
    endtask

    initial begin
        for (int n = 0; n < 10; n++) begin g1s[n] = 1; g2s[n] = 1; end
        for (int n = 0; n < 1023; n++) begin
            g1s[n+10] = g1s[n+7] ^ g1s[n];
            g2s[n+10] = g2s[n+8] ^ g2s[n+7] ^ g2s[n+4] ^ g2s[n+2] ^ g2s[n+1] ^ g2s[n];
        end
        bus.chip_clk = 1'b0; bus.enable = 1'b1; bus.load = 1'b0; bus.prn = '0;
        model_reset();
        n_ep = 0; n_be = 0;
        cyc(); cyc();
        check_all("reset");
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) do_strobe(1'b1);
        check_all("no_load");

        do_load(1, 1'b0);
        first10("prn1_first10", 10'o1440);
        do_load(2, 1'b0);
        first10("prn2_first10", 10'o1620);

        do_load(0, 1'b0);
        for (int i = 0; i < 3; i++) do_strobe(1'b1);
        do_load(33, 1'b0);
        for (int i = 0; i < 3; i++) do_strobe(1'b1);
        do_load(int'($urandom_range(34, 63)), 1'b0);
        do_strobe(1'b1);

        do_load(1, 1'b0);
        for (int i = 0; i < 500; i++) do_strobe(1'b1);
        chk("idx500", 32'(bus.chip_idx), 32'd500);
        do_load(1, 1'b1);
        chk("load_wins", 32'(bus.chip_idx), 32'd0);
        for (int i = 0; i < 7; i++) do_strobe(1'b1);
        for (int i = 0; i < 5; i++) do_strobe(1'b0);
        chk("enable_low", 32'(bus.chip_idx), 32'd7);

        for (int r = 0; r < 6; r++) begin
            do_load(int'($urandom_range(1, 32)), 1'b0);
            for (int i = 0; i < int'($urandom_range(20, 250)); i++) begin
                do_strobe($urandom_range(0, 4) != 0);
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    cyc();
                    check_all("gap");
                end
            end
        end

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) do_strobe(1'b1);
        chk("post_reset_idx", 32'(bus.chip_idx), 32'd0);

        do_load(1, 1'b0);
        n_ep = 0; n_be = 0;
        for (int i = 0; i < 1023; i++) do_strobe(1'b1);
        chk("one_epoch", 32'(n_ep), 32'd1);
        first10("prn1_repeat", 10'o1440);
        for (int i = 0; i < 20 * 1023 - 1033; i++) do_strobe(1'b1);
        chk("epochs20", 32'(n_ep), 32'd20);
        chk("bit_edges", 32'(n_be), 32'd1);
        chk("ms_wrap", 32'(bus.ms_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
